// File: rtl/diff_tx_arbiter.sv
// diff_tx_arbiter
// Shares one tristate differential output buffer (OBUFTDS) between two
// requesters. Each accepted byte is sent as one frame: PRE_CYCLES of
// driven idle (1), eight data bits LSB first (BIT_CYCLES each), one stop
// bit (1, BIT_CYCLES), then GAP_CYCLES of tristated turnaround.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         permits new frames to be granted (never aborts a frame)
//   req_valid  per-requester byte valid
//   req_data0  requester 0 byte
//   req_data1  requester 1 byte
//   req_ready  per-requester accept (combinational, at most one bit set)
//   obuf_i     OBUFTDS I (registered)
//   obuf_t     OBUFTDS T, 1 = tristate (registered)
//   busy       frame in progress (registered)
//   done       one-cycle pulse on frame completion (registered)
//   done_id    requester of the completed frame (registered)
//
// state | meaning
// IDLE  | line tristated, waiting for a granted request
// PRE   | driven idle high before the first data bit
// DATA  | eight data bits, LSB first
// STOP  | stop bit, driven high
// GAP   | tristated turnaround, then done pulse on return to IDLE

module diff_tx_arbiter #(
  parameter int BIT_CYCLES = 4,
  parameter int PRE_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       obuf_i,
  output logic       obuf_t,
  output logic       busy,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_STOP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // Down-counter reload values: a phase lasting N cycles loads N-1.
  localparam logic [7:0] PRE_LD = 8'(PRE_CYCLES - 1);
  localparam logic [7:0] BIT_LD = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       id_q, id_d;
  logic       last_q, last_d;
  logic       obuf_i_q, obuf_i_d;
  logic       obuf_t_q, obuf_t_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       done_id_q, done_id_d;

  logic       grant;
  logic       hs;

  // Requester 1 wins when it is the only one valid, or when both are valid
  // and requester 0 was served last.
  always_comb begin
    grant = req_valid[1] & (~req_valid[0] | ~last_q);
    req_ready = 2'b00;
    if (!rst && state_q == S_IDLE && en)
      req_ready = req_valid & (grant ? 2'b10 : 2'b01);
    hs = |req_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          data_d  = grant ? req_data1 : req_data0;
          id_d    = grant;
          last_d  = grant;
          state_d = S_PRE;
          cnt_d   = PRE_LD;
          bit_d   = 3'd0;
        end
      end
      S_PRE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DATA;
          cnt_d   = BIT_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 8'd0) begin
          cnt_d = BIT_LD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        bit_d   = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so the pins move on the same
    // edge the FSM does (first edge after handshake).
    obuf_t_d  = (state_d == S_IDLE) || (state_d == S_GAP);
    obuf_i_d  = (state_d == S_DATA) ? data_q[bit_d] : 1'b1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_GAP) && (state_d == S_IDLE);
    done_id_d = done_d ? id_q : done_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      data_q    <= 8'd0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      obuf_i_q  <= 1'b1;
      obuf_t_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      id_q      <= id_d;
      last_q    <= last_d;
      obuf_i_q  <= obuf_i_d;
      obuf_t_q  <= obuf_t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign obuf_i  = obuf_i_q;
  assign obuf_t  = obuf_t_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_diff_tx_arbiter.sv
// Testbench for diff_tx_arbiter: a cycle-level reference model predicts
// req_ready/busy and queues each accepted (requester, byte); a separate
// monitor decodes the line waveform and done pulse against that queue.
// A second instance with 1-cycle parameters gets a short directed check.

module tb_diff_tx_arbiter;

  localparam int BIT = 4;
  localparam int PRE = 2;
  localparam int GAP = 2;
  localparam int DRV = PRE + 9 * BIT;   // driven cycles per frame
  localparam int TOT = DRV + GAP;       // busy cycles per frame

  logic       clk, rst, en;
  logic [1:0] req_valid;
  logic [7:0] req_data0, req_data1;
  logic [1:0] req_ready;
  logic       obuf_i, obuf_t, busy, done, done_id;

  logic [1:0] v1;
  logic [7:0] d1;
  logic [1:0] rdy1;
  logic       oi1, ot1, busy1, done1, did1;

  int vec_m, err_m, vec_s, err_s, vec_d, err_d;

  logic [8:0] sb_q[$];

  diff_tx_arbiter #(.BIT_CYCLES(BIT), .PRE_CYCLES(PRE), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .obuf_i(obuf_i), .obuf_t(obuf_t), .busy(busy), .done(done), .done_id(done_id)
  );

  diff_tx_arbiter #(.BIT_CYCLES(1), .PRE_CYCLES(1), .GAP_CYCLES(1)) u_dut_min (
    .clk(clk), .rst(rst), .en(1'b1), .req_valid(v1),
    .req_data0(d1), .req_data1(8'h00), .req_ready(rdy1),
    .obuf_i(oi1), .obuf_t(ot1), .busy(busy1), .done(done1), .done_id(did1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: idle when no frame is outstanding; the frame occupies
  // exactly TOT cycles after the accepting edge.
  int   m_cnt;
  logic m_last;
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic       g;
    exp_rdy = 2'b00;
    if (rst) begin
      m_cnt  = 0;
      m_last = 1'b1;
    end else if (m_cnt == 0 && en && req_valid != 2'b00) begin
      if (req_valid == 2'b01)      g = 1'b0;
      else if (req_valid == 2'b10) g = 1'b1;
      else                         g = ~m_last;
      exp_rdy = g ? 2'b10 : 2'b01;
    end
    vec_m++;
    if (req_ready !== exp_rdy || busy !== (m_cnt > 0)) begin
      err_m++;
      $display("FAIL ready_busy t=%0t got ready=%b busy=%b expected ready=%b busy=%b",
               $time, req_ready, busy, exp_rdy, (m_cnt > 0));
    end
    if (!rst) begin
      if (m_cnt > 0) m_cnt--;
      if (exp_rdy != 2'b00) begin
        sb_q.push_back({g, g ? req_data1 : req_data0});
        m_last = g;
        m_cnt  = TOT;
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i < PRE) return 1'b1;
    if (i < PRE + 8 * BIT) return b[3'((i - PRE) / BIT)];
    return 1'b1;
  endfunction

  // Monitor: a frame starts when the line leaves tristate.
  logic       mact;
  int         mpos, mbad_idx;
  logic [8:0] cur;
  always @(negedge clk) begin
    if (rst) begin
      mact = 1'b0;
      mpos = 0;
      sb_q.delete();
    end else if (!mact) begin
      if (obuf_t == 1'b0) begin
        if (sb_q.size() == 0) begin
          vec_s++; err_s++;
          $display("FAIL unexpected_frame t=%0t got obuf_t=0 required obuf_t=1", $time);
        end else begin
          cur = sb_q.pop_front();
          mact = 1'b1;
          mpos = 0;
          mbad_idx = -1;
        end
      end else begin
        vec_s++;
        if (done !== 1'b0) begin
          err_s++;
          $display("FAIL spurious_done t=%0t got done=%b required 0", $time, done);
        end
      end
    end
    if (!rst && mact) begin
      if (mpos < DRV) begin
        if (mbad_idx < 0 && (obuf_t !== 1'b0 || obuf_i !== exp_bit(cur[7:0], mpos)))
          mbad_idx = mpos;
        if (mpos == DRV - 1) begin
          vec_s++;
          if (mbad_idx >= 0) begin
            err_s++;
            $display("FAIL frame_wave id=%0d byte=%h first bad sample %0d got t=%b i=%b required t=0 i=%b",
                     cur[8], cur[7:0], mbad_idx, obuf_t, obuf_i, exp_bit(cur[7:0], mbad_idx));
          end
        end
      end else if (mpos < TOT) begin
        vec_s++;
        if (obuf_t !== 1'b1 || obuf_i !== 1'b1 || done !== 1'b0) begin
          err_s++;
          $display("FAIL gap t=%0t got t=%b i=%b done=%b required t=1 i=1 done=0",
                   $time, obuf_t, obuf_i, done);
        end
      end else begin
        vec_s++;
        if (done !== 1'b1 || done_id !== cur[8]) begin
          err_s++;
          $display("FAIL done_pulse t=%0t got done=%b id=%b required done=1 id=%b",
                   $time, done, done_id, cur[8]);
        end
        mact = 1'b0;
      end
      mpos++;
    end
  end

  task automatic dchk(input string name, input logic [7:0] got, input logic [7:0] want);
    vec_d++;
    if (got !== want) begin
      err_d++;
      $display("FAIL %s got %b required %b", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    vec_m = 0; err_m = 0; vec_s = 0; err_s = 0; vec_d = 0; err_d = 0;
    rst = 1'b1; en = 1'b0; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
    v1 = 2'b00; d1 = 8'h00;
    #3;
    dchk("reset_state", {2'b00, req_ready, obuf_t, obuf_i, busy, done, done_id},
         8'b00_00_1_1_0_0_0);
    cyc(2);
    rst = 1'b0;

    // Contention: four back-to-back frames alternating 0,1,0,1.
    en = 1'b1; req_valid = 2'b11; req_data0 = 8'h01; req_data1 = 8'h80;
    cyc(4 * (TOT + 1) - 5);
    req_valid = 2'b00;
    cyc(50);

    // Single frame from requester 0.
    req_valid = 2'b01; req_data0 = 8'hA5;
    cyc(1);
    req_valid = 2'b00; req_data0 = 8'h00;
    cyc(50);

    // Gating, then enable with the request already pending.
    en = 1'b0; req_valid = 2'b10; req_data1 = 8'h3C;
    cyc(60);
    en = 1'b1;
    cyc(1);
    req_valid = 2'b00; req_data1 = 8'hC3;
    cyc(50);

    // Mid-frame reset during data bit 3.
    req_valid = 2'b01; req_data0 = 8'h5A;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (busy) begin seen = 1'b1; break; end
    end
    vec_d++;
    if (!seen) begin
      err_d++;
      $display("FAIL busy_timeout got busy=0 required busy=1 within 5 cycles");
    end
    req_valid = 2'b00;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1 dchk("async_reset", {5'b0, obuf_t, busy, done}, 8'b00000_1_0_0);
    @(negedge clk);
    cyc(1);
    rst = 1'b0;
    req_valid = 2'b11; req_data0 = 8'h11; req_data1 = 8'h22;
    cyc(1);
    req_valid = 2'b00;
    cyc(50);

    // Randomized traffic; data also changes under frames in flight.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      req_valid = 2'($urandom_range(0, 3));
      req_data0 = 8'($urandom);
      req_data1 = 8'($urandom);
      cyc(1);
    end
    req_valid = 2'b00; en = 1'b1;
    cyc(60);

    // Minimum-parameter instance: 0xFF frame of 11 cycles.
    v1 = 2'b01; d1 = 8'hFF;
    @(negedge clk);
    dchk("min_ready", {6'b0, rdy1}, 8'b0000_0001);
    cyc(1);
    v1 = 2'b00; d1 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] w;
      @(negedge clk);
      if (i < 10)       w = 4'b1010;
      else if (i == 10) w = 4'b1110;
      else              w = 4'b0111;
      dchk($sformatf("min_frame_c%0d", i), {4'b0, busy1, ot1, oi1, done1}, {4'b0, w});
    end
    @(negedge clk);
    dchk("min_idle", {4'b0, busy1, ot1, done1, did1}, 8'b0000_0100);

    vec_d++;
    if (sb_q.size() != 0 || mact) begin
      err_d++;
      $display("FAIL drain got pending=%0d active=%b required pending=0 active=0",
               sb_q.size(), mact);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_m + vec_s + vec_d, err_m + err_s + err_d);
    $finish;
  end

endmodule

// File: doc/diff_tx_arbiter.md
DIFF_TX_ARBITER -- requirements
Module: diff_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 4, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 The block SHALL have parameter PRE_CYCLES, default 2, meaning driven-idle cycles before the first data bit (legal range 1..255).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, meaning tristated turnaround cycles after the stop bit (legal range 1..255).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock), rst input 1 (async active-high reset).
REQ-005 The block SHALL have ports: en input 1 (permit new frames); req_valid input 2 (per-requester byte valid); req_data0 input 8 (requester 0 byte); req_data1 input 8 (requester 1 byte); req_ready output 2 (per-requester byte accepted); obuf_i output 1 (to OBUFTDS I); obuf_t output 1 (to OBUFTDS T, 1 = tristate); busy output 1 (frame in progress); done output 1 (frame-complete pulse); done_id output 1 (requester of the completed frame).

Function
REQ-006 The block SHALL share one tristate differential output buffer between two requesters, serialising one byte per frame.
REQ-007 The FSM SHALL have states IDLE, PRE, DATA, STOP, GAP.
REQ-008 In IDLE: obuf_t=1, obuf_i=1, busy=0.
REQ-009 In IDLE with en=1 and any req_valid bit set, grant SHALL be: the only valid requester; if both are valid, the requester not equal to last_grant.
REQ-010 req_ready SHALL be combinational, with bit g=1 only when state=IDLE, en=1, req_valid[g]=1 and g is granted; at most one bit is set.
REQ-011 On handshake (valid&ready), the block SHALL latch the byte and grant id, update last_grant, and enter PRE on the next edge.
REQ-012 In PRE: obuf_t=0, obuf_i=1, for exactly PRE_CYCLES cycles.
REQ-013 In DATA: obuf_t=0; 8 bits driven LSB first on obuf_i, each held exactly BIT_CYCLES cycles.
REQ-014 In STOP: obuf_t=0, obuf_i=1, for BIT_CYCLES cycles.
REQ-015 In GAP: obuf_t=1, obuf_i=1, for GAP_CYCLES cycles; the FSM then returns to IDLE.
REQ-016 obuf_i, obuf_t, busy, done and done_id SHALL be registered outputs; obuf_t/obuf_i SHALL change on the first edge after handshake.
REQ-017 busy SHALL be 1 in every cycle the FSM is in PRE, DATA, STOP or GAP.
REQ-018 Frame length SHALL be PRE_CYCLES+9*BIT_CYCLES+GAP_CYCLES cycles (40 at defaults).
REQ-019 done SHALL pulse for exactly 1 cycle on the GAP->IDLE transition, with done_id = the served requester.
REQ-020 A new handshake SHALL be possible in the first IDLE cycle after GAP (back-to-back frames; no extra idle cycle).
REQ-021 en deasserted mid-frame SHALL NOT abort the frame; it only blocks new grants in IDLE.
REQ-022 req_valid or req_data changes after handshake SHALL NOT affect the frame in flight.
REQ-023 The bit counter (0..7) and the cycle counter (width ceil(log2(255))=8 bits) SHALL reload on each state or bit change; no wrap beyond their terminal values.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, obuf_t=1, obuf_i=1, busy=0, done=0, done_id=0, counters=0, last_grant=1 (requester 0 wins the first contention).
REQ-025 Reset asserted mid-frame SHALL tristate the line immediately, discard the frame and produce no done pulse.
REQ-026 req_ready SHALL be 0 while rst=1.

Verification
REQ-027 Single frame: defaults, req_valid=01, req_data0=0xA5 -> req_ready=01 for 1 cycle; obuf_t=0 for 38 cycles; obuf_i = 1,1 then bits 1,0,1,0,0,1,0,1 (4 cycles each) then 1 x4; obuf_t=1 for 2 cycles; done=1, done_id=0.
REQ-028 Contention: after reset, req_valid=11 held, data0=0x01, data1=0x80 -> frames served 0,1,0,1; done_id alternates; each frame is 40 cycles with no idle gap.
REQ-029 Gating: en=0, req_valid=10 -> req_ready=00 and obuf_t=1 indefinitely; set en=1 -> req_ready=10 in the same cycle.
REQ-030 Mid-frame reset: assert rst during DATA bit 3 -> obuf_t=1, busy=0 the same cycle without a clock edge; no done pulse; next frame is served from requester 0.
REQ-031 Parameters BIT_CYCLES=1, PRE_CYCLES=1, GAP_CYCLES=1, byte 0xFF -> frame of 11 cycles, obuf_i=1 throughout, done after cycle 11.
REQ-032 Data change: alter req_data1 during a requester-1 frame -> the serialised byte equals the value latched at handshake.
